mem_req_initiator: RTL and testbench
====================================

Name: mem_req_initiator

Overview:
- Bus initiator that drives the single-outstanding req/busy/valid memory interface used by the simulated instruction/data memory.
- Arbitrates between a read-only instruction-fetch client and a read/write data client.
- Issues one transaction at a time and returns read data or write completion to the granted client.
- Sits between the core's fetch/LSU stages and the memory model.

Parameters:
- ADDR_W, 32, address width forwarded to memory
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted (combinational, IDLE only)
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  0 = read, 1 = write
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted
- d_done  out  1  one-cycle pulse; read data valid or write complete
- d_rdata  out  DATA_W  data read data
- err  out  1  one-cycle timeout pulse, coincident with rvalid/done
- mem_req  out  1  one-cycle transaction start
- mem_we  out  1  write enable; held stable for the whole transaction
- mem_addr  out  ADDR_W  address; held stable for the whole transaction
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  memory read data
- mem_busy  in  1  memory operation in progress
- mem_valid  in  1  one-cycle read-complete pulse

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0, state IDLE, last_grant = DATA so fetch wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If mem_busy = 0 and any request is present, grant one client.
  - Only one requester: it wins.
  - Both request: round-robin, the client not in last_grant wins.
  - Gnt is asserted in that same cycle.
  - Latch addr, we (fetch forces we = 0) and wdata into mem_* registers; record the client id; go to ISSUE.
- ISSUE: mem_req = 1 for exactly one cycle -> WAIT.
- WAIT:
  - mem_req = 0; mem_we/mem_addr/mem_wdata held.
  - Read completes on the cycle mem_valid = 1: capture mem_rdata -> RESP.
  - Write completes on the first WAIT cycle with mem_busy = 0 after busy was seen high -> RESP.
  - mem_valid while the latched we = 1 is ignored.
  - busy not yet seen high: the first WAIT cycle with mem_busy = 0 is not treated as completion.
- RESP:
  - Pulse if_rvalid or d_done for one cycle, with rdata driven that cycle.
  - Read data registers hold their value until the next completion.
  - Update last_grant, then go to IDLE.
  - A new grant is possible on the next cycle.
- Latency: gnt cycle to rvalid/done = memory LATENCY + 3 cycles (6 for LATENCY = 3). Throughput is one transaction per LATENCY + 4 cycles.
- Gnt is never asserted outside IDLE; client requests in other states simply wait.
- Addresses are forwarded unmodified; the low two bits are not checked.
- Reset mid-transaction: return immediately to IDLE with all outputs 0; the outstanding transaction is dropped with no response.

Optional Feature:
- MEM_REQ_INITIATOR_TIMEOUT_EN defined:
  - A WAIT-cycle counter of width $clog2(TIMEOUT_CYCLES+1) runs while in WAIT.
  - On reaching TIMEOUT_CYCLES without completion, go to RESP with rdata = 32'hDEAD_BEEF and err = 1 alongside the client pulse.
  - The counter clears on entry to WAIT.
- Undefined: no counter; WAIT waits indefinitely; err tied 0.

Decomposition:
- Package mem_if_pkg:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - client_e (CL_FETCH/CL_DATA)
  - TIMEOUT_DATA = 32'hDEAD_BEEF
- One sub-module, rr_arbiter2: two requests plus last_grant in, one-hot grant out; combinational.

Test Plan:
- Fetch-only read, memory LATENCY = 3, mem[4] = 32'h0000_0013, if_addr = 32'h10 -> if_gnt in cycle 0; mem_req high only in cycle 1; if_rvalid in cycle 6 with if_rdata = 32'h0000_0013.
- Data write 32'hCAFE_F00D to 32'h20, then data read of 32'h20 -> d_done pulse for the write, no if_rvalid; the read returns 32'hCAFE_F00D.
- if_req and d_req both held continuously -> grants alternate fetch, data, fetch, data; mem_we/mem_addr stable across every WAIT.
- rst_n pulsed low during WAIT -> all outputs 0 asynchronously; no rvalid/done for the dropped transaction; a fresh request after reset completes normally.
- With MEM_REQ_INITIATOR_TIMEOUT_EN and TIMEOUT_CYCLES = 8, mem_busy stuck at 1 -> d_done and err pulse after 8 WAIT cycles, d_rdata = 32'hDEAD_BEEF.
- Read with mem_valid during a write transaction forced high -> the write still completes on busy falling; no spurious rdata update.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types for the single-outstanding memory request initiator.
package mem_if_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic {
      CL_FETCH = 1'b0,
      CL_DATA  = 1'b1
   } client_e;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-client round-robin arbiter; bit 0 = fetch, bit 1 = data. Purely combinational.
module rr_arbiter2
   import mem_if_pkg::*;
(
   input  logic       i_en,
   input  logic       i_req_if,
   input  logic       i_req_d,
   input  client_e    i_last,
   output logic [1:0] o_gnt
);

   // A lone requester always wins; on a tie the client not granted last time wins.
   always_comb begin
      o_gnt = 2'b00;
      if (i_en) begin
         if (i_req_if && i_req_d) begin
            o_gnt = (i_last == CL_DATA) ? 2'b01 : 2'b10;
         end else begin
            o_gnt = {i_req_d, i_req_if};
         end
      end
   end

endmodule

// File: rtl/mem_req_initiator.sv
// Single-outstanding memory bus initiator arbitrating fetch and data clients.
// Optional WAIT-state timeout enabled by defining MEM_REQ_INITIATOR_TIMEOUT_EN.
module mem_req_initiator
   import mem_if_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_busy,
   input  logic              mem_valid
);

   state_e            r_state;
   state_e            w_next;
   client_e           r_client;
   client_e           r_last;
   logic              r_busy_seen;
   logic              w_arb_en;
   logic [1:0]        w_gnt;
   logic              w_timeout;
   logic [DATA_W-1:0] w_rsp_data;

   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_if_rvalid;
   logic              r_d_done;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;

   // Grants only in IDLE with an idle memory; reset forces them low immediately.
   assign w_arb_en = rst_n && (r_state == ST_IDLE) && !mem_busy;

   rr_arbiter2 u_arb (
      .i_en     (w_arb_en),
      .i_req_if (if_req),
      .i_req_d  (d_req),
      .i_last   (r_last),
      .o_gnt    (w_gnt)
   );

   assign if_gnt    = w_gnt[0];
   assign d_gnt     = w_gnt[1];
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign if_rvalid = r_if_rvalid;
   assign if_rdata  = r_if_rdata;
   assign d_done    = r_d_done;
   assign d_rdata   = r_d_rdata;

`ifdef MEM_REQ_INITIATOR_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_err;

   // WAIT-cycle counter, cleared while entering WAIT from ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_timeout;
         if (r_state == ST_ISSUE) begin
            r_wait_cnt <= '0;
         end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
         end
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic and completion / timeout detection.
   always_comb begin
      w_next     = r_state;
      w_timeout  = 1'b0;
      w_rsp_data = mem_rdata;
      case (r_state)
         ST_IDLE: begin
            if (|w_gnt) w_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            w_next = ST_WAIT;
         end
         ST_WAIT: begin
            if ((!r_mem_we && mem_valid) || (r_mem_we && !mem_busy && r_busy_seen)) begin
               w_next = ST_RESP;
            end
`ifdef MEM_REQ_INITIATOR_TIMEOUT_EN
            else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_timeout  = 1'b1;
               w_rsp_data = DATA_W'(TIMEOUT_DATA);
               w_next     = ST_RESP;
            end
`endif
         end
         ST_RESP: begin
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Client bookkeeping: granted id, round-robin history, busy-seen flag for writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_client    <= CL_FETCH;
         r_last      <= CL_DATA;
         r_busy_seen <= 1'b0;
      end else begin
         if (|w_gnt) r_client <= w_gnt[1] ? CL_DATA : CL_FETCH;
         if (r_state == ST_RESP) r_last <= r_client;
         if (r_state == ST_ISSUE) begin
            r_busy_seen <= 1'b0;
         end else if ((r_state == ST_WAIT) && mem_busy) begin
            r_busy_seen <= 1'b1;
         end
      end
   end

   // Registered bus and client-response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rvalid <= 1'b0;
         r_d_done    <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
      end else begin
         r_mem_req   <= (r_state == ST_IDLE) && (|w_gnt);
         r_if_rvalid <= (w_next == ST_RESP) && (r_client == CL_FETCH);
         r_d_done    <= (w_next == ST_RESP) && (r_client == CL_DATA);
         if (|w_gnt) begin
            r_mem_we    <= w_gnt[1] & d_we;
            r_mem_addr  <= w_gnt[1] ? d_addr : if_addr;
            r_mem_wdata <= w_gnt[1] ? d_wdata : '0;
         end
         if ((w_next == ST_RESP) && (w_timeout || !r_mem_we)) begin
            if (r_client == CL_FETCH) r_if_rdata <= w_rsp_data;
            else                      r_d_rdata  <= w_rsp_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator with a LATENCY = 3 memory model.
module tb_mem_req_initiator;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic        if_gnt, if_rvalid, d_gnt, d_done, err;
   logic [31:0] if_rdata, d_rdata;
   logic        mem_req, mem_we, mem_busy, mem_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        stuck_busy, force_valid;
   logic        m_busy, m_valid, m_we;
   logic [31:0] m_rdata, m_addr, m_wd;
   int          m_cnt;
   logic [31:0] mem [0:63];

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   mem_req_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_valid(mem_valid)
   );

   assign mem_busy  = m_busy | stuck_busy;
   assign mem_valid = m_valid | force_valid;
   assign mem_rdata = force_valid ? 32'h0BAD_0BAD : m_rdata;

   // Memory model: busy for LAT cycles after mem_req, then read-valid pulse or write commit.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_cnt   <= 0;
         m_rdata <= 32'h0;
         mem[4]  <= 32'h0000_0013;
      end else begin
         m_valid <= 1'b0;
         if (m_busy) begin
            if (m_cnt == 1) begin
               m_busy <= 1'b0;
               if (m_we) mem[m_addr[7:2]] <= m_wd;
               else begin
                  m_valid <= 1'b1;
                  m_rdata <= mem[m_addr[7:2]];
               end
            end
            m_cnt <= m_cnt - 1;
         end else if (mem_req) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT;
            m_we   <= mem_we;
            m_addr <= mem_addr;
            m_wd   <= mem_wdata;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Issues one request from IDLE and waits (bounded) for the client response.
   task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input bit sb, input bit fv,
                          output logic [1:0] gnt, output int lat, output logic [1:0] resp,
                          output logic [31:0] rd, output logic e, output logic iss_we,
                          output logic mreq1, output int n_mreq);
      tick;
      if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; end
      else      begin if_req = 1'b1; if_addr = addr; end
      #1;
      gnt    = {d_gnt, if_gnt};
      n_mreq = int'(mem_req);
      tick;
      if_req = 1'b0; d_req = 1'b0;
      stuck_busy  = sb;
      force_valid = fv;
      iss_we = mem_we;
      mreq1  = mem_req;
      lat    = 1;
      n_mreq += int'(mem_req);
      while (lat < 40 && !(if_rvalid || d_done)) begin
         tick;
         lat++;
         n_mreq += int'(mem_req);
      end
      resp = {d_done, if_rvalid};
      rd   = is_d ? d_rdata : if_rdata;
      e    = err;
      stuck_busy  = 1'b0;
      force_valid = 1'b0;
   endtask

   initial begin
      logic [1:0]  gnt, resp;
      logic [31:0] rd, exp_addr, exp_drd;
      logic        e, iss_we, mreq1, exp_we, got;
      logic [3:0]  order;
      int          lat, n_mreq, ng, bad, gap_bad, last_gc, spur;

      rst_n = 1'b0;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      stuck_busy = 1'b0; force_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if_req = 1'b1;
      #1;
      chk("rst_gnt", 32'(if_gnt), 32'd0);
      chk("rst_ctl", {27'd0, mem_req, mem_we, if_rvalid, d_done, err}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_rdata", if_rdata | d_rdata, 32'd0);
      if_req = 1'b0;
      rst_n  = 1'b1;

      // Fetch-only read of mem[4]
      run_txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, gnt, lat, resp, rd, e, iss_we, mreq1, n_mreq);
      chk("t1_gnt", 32'(gnt), 32'b01);
      chk("t1_mreq_c1", 32'(mreq1), 32'd1);
      chk("t1_mreq_cnt", 32'(n_mreq), 32'd1);
      chk("t1_lat", 32'(lat), 32'd6);
      chk("t1_resp", 32'(resp), 32'b01);
      chk("t1_rdata", rd, 32'h0000_0013);
      chk("t1_err", 32'(e), 32'd0);
      tick;
      chk("t1_rvalid_pulse", 32'(if_rvalid), 32'd0);
      chk("t1_rdata_hold", if_rdata, 32'h0000_0013);

      // Data write then read-back of the same address
      run_txn(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b0, gnt, lat, resp, rd, e, iss_we, mreq1, n_mreq);
      chk("t2w_gnt", 32'(gnt), 32'b10);
      chk("t2w_we", 32'(iss_we), 32'd1);
      chk("t2w_lat", 32'(lat), 32'd6);
      chk("t2w_resp", 32'(resp), 32'b10);
      chk("t2w_rdata_untouched", rd, 32'd0);
      chk("t2w_wdata", mem_wdata, 32'hCAFE_F00D);
      run_txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, gnt, lat, resp, rd, e, iss_we, mreq1, n_mreq);
      chk("t2r_gnt", 32'(gnt), 32'b10);
      chk("t2r_resp", 32'(resp), 32'b10);
      chk("t2r_lat", 32'(lat), 32'd6);
      chk("t2r_rdata", rd, 32'hCAFE_F00D);

      // Both clients held: grants alternate starting with fetch (last grant was data)
      tick;
      if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'h0000_1234;
      ng = 0; bad = 0; gap_bad = 0; last_gc = -100; order = '0;
      exp_addr = '0; exp_we = 1'b0;
      for (int c = 0; c < 60 && ng < 4; c++) begin
         #1;
         if (if_gnt || d_gnt) begin
            if (if_gnt && d_gnt) bad++;
            order[ng] = d_gnt;
            if (ng > 0 && (c - last_gc) != LAT + 4) gap_bad++;
            last_gc  = c;
            exp_addr = d_gnt ? 32'h24 : 32'h10;
            exp_we   = d_gnt;
            ng++;
         end else if (ng > 0) begin
            if (mem_addr !== exp_addr || mem_we !== exp_we) bad++;
         end
         @(posedge clk);
         #1;
      end
      if_req = 1'b0; d_req = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (mem_addr !== exp_addr || mem_we !== exp_we) bad++;
         if (d_done) begin got = 1'b1; break; end
         tick;
      end
      chk("t3_ngrants", 32'(ng), 32'd4);
      chk("t3_order", 32'(order), 32'b1010);
      chk("t3_spacing", 32'(gap_bad), 32'd0);
      chk("t3_stable", 32'(bad), 32'd0);
      chk("t3_last_done", 32'(got), 32'd1);

      // Reset asserted mid-WAIT drops the transaction
      tick;
      if_req = 1'b1; if_addr = 32'h10;
      tick;
      if_req = 1'b0;
      tick;
      tick;
      rst_n = 1'b0;
      #1;
      chk("t4_rst_ctl", {27'd0, mem_req, mem_we, if_rvalid, d_done, err}, 32'd0);
      chk("t4_rst_addr", mem_addr, 32'd0);
      chk("t4_rst_rdata", if_rdata | d_rdata, 32'd0);
      tick;
      tick;
      rst_n = 1'b1;
      spur = 0;
      for (int c = 0; c < 10; c++) begin
         tick;
         if (if_rvalid || d_done || mem_req) spur++;
      end
      chk("t4_no_resp", 32'(spur), 32'd0);
      run_txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, gnt, lat, resp, rd, e, iss_we, mreq1, n_mreq);
      chk("t4_fresh_resp", 32'(resp), 32'b10);
      chk("t4_fresh_lat", 32'(lat), 32'd6);
      chk("t4_fresh_rdata", rd, 32'hCAFE_F00D);
      exp_drd = 32'hCAFE_F00D;

`ifdef MEM_REQ_INITIATOR_TIMEOUT_EN
      // Memory stuck busy: timeout after 8 WAIT cycles
      run_txn(1'b1, 1'b1, 32'h2C, 32'h77, 1'b1, 1'b0, gnt, lat, resp, rd, e, iss_we, mreq1, n_mreq);
      chk("t5_lat", 32'(lat), 32'd10);
      chk("t5_resp", 32'(resp), 32'b10);
      chk("t5_err", 32'(e), 32'd1);
      chk("t5_rdata", rd, 32'hDEAD_BEEF);
      tick;
      chk("t5_err_pulse", 32'(err), 32'd0);
      exp_drd = 32'hDEAD_BEEF;
`endif

      // Write with mem_valid forced high: completes on busy falling, no rdata update
      run_txn(1'b1, 1'b1, 32'h28, 32'h5555_AAAA, 1'b0, 1'b1, gnt, lat, resp, rd, e, iss_we, mreq1, n_mreq);
      chk("t6_lat", 32'(lat), 32'd6);
      chk("t6_resp", 32'(resp), 32'b10);
      chk("t6_rdata_hold", rd, exp_drd);
      chk("t6_err", 32'(e), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
